// File: rtl/apb_arbiter_if.sv
// rtl/apb_arbiter_if.sv - APB bus bundle between the arbiter (master) and a single slave
interface apb_arbiter_if #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
) ();
    logic [addrWidth-1:0] paddr;
    logic                 pwrite;
    logic                 psel;
    logic                 penable;
    logic [dataWidth-1:0] pwdata;
    logic [dataWidth-1:0] prdata;
    logic                 pready;

    modport master (
        output paddr, pwrite, psel, penable, pwdata,
        input  prdata, pready
    );

    modport slave (
        input  paddr, pwrite, psel, penable, pwdata,
        output prdata, pready
    );
endinterface

// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - two-requester round-robin arbiter onto one APB master; optional timeout via APB_ARB_TIMEOUT_EN
module apb_arbiter #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
) (
    input  logic                 pclk,
    input  logic                 rst,

    input  logic                 req0_valid,
    input  logic                 req0_write,
    input  logic [addrWidth-1:0] req0_addr,
    input  logic [dataWidth-1:0] req0_wdata,
    output logic                 req0_ready,
    output logic                 req0_done,
    output logic [dataWidth-1:0] req0_rdata,
    output logic                 req0_err,

    input  logic                 req1_valid,
    input  logic                 req1_write,
    input  logic [addrWidth-1:0] req1_addr,
    input  logic [dataWidth-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic                 req1_done,
    output logic [dataWidth-1:0] req1_rdata,
    output logic                 req1_err,

    apb_arbiter_if.master        apb
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t               state, state_nxt;
    logic                 rr_ptr;      // requester favoured when both are valid
    logic                 owner;       // requester whose transfer is on the bus
    logic                 grant0, grant1;
    logic                 psel_c, penable_c;
    logic                 finish;      // transfer ends at this edge
    logic                 timeout;

    logic [addrWidth-1:0] paddr_q;
    logic                 pwrite_q;
    logic [dataWidth-1:0] pwdata_q;
    logic                 done0_q, done1_q, err0_q, err1_q;
    logic [dataWidth-1:0] rdata0_q, rdata1_q;

`ifdef APB_ARB_TIMEOUT_EN
    logic [3:0] wait_cnt;

    // Count consecutive wait cycles in ACCESS; cleared while in SETUP so it starts at 0 on entry.
    always_ff @(posedge pclk) begin
        if (rst) begin
            wait_cnt <= 4'd0;
        end else if (state == SETUP) begin
            wait_cnt <= 4'd0;
        end else if (state == ACCESS && !apb.pready) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // The 16th wait cycle in a row gives up on the slave.
    assign timeout = (state == ACCESS) && !apb.pready && (wait_cnt == 4'hF);
`else
    assign timeout = 1'b0;
`endif

    assign finish = (state == ACCESS) && (apb.pready || timeout);

    // State register.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grant selection and APB phase controls.
    always_comb begin
        state_nxt = state;
        grant0    = 1'b0;
        grant1    = 1'b0;
        psel_c    = 1'b0;
        penable_c = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req0_valid && (!req1_valid || !rr_ptr);
                grant1 = req1_valid && (!req0_valid ||  rr_ptr);
                if (grant0 || grant1) begin
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                psel_c    = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel_c    = 1'b1;
                penable_c = 1'b1;
                if (apb.pready || timeout) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command capture on acceptance and completion reporting one cycle after the transfer ends.
    always_ff @(posedge pclk) begin
        if (rst) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            owner    <= 1'b0;
            rr_ptr   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
            if (grant0 || grant1) begin
                paddr_q  <= grant1 ? req1_addr  : req0_addr;
                pwrite_q <= grant1 ? req1_write : req0_write;
                pwdata_q <= grant1 ? req1_wdata : req0_wdata;
                owner    <= grant1;
                rr_ptr   <= ~grant1;
            end
            if (finish) begin
                if (!owner) begin
                    done0_q <= 1'b1;
                    err0_q  <= timeout;
                    if (timeout) begin
                        rdata0_q <= '0;
                    end else if (!pwrite_q) begin
                        rdata0_q <= apb.prdata;
                    end
                end else begin
                    done1_q <= 1'b1;
                    err1_q  <= timeout;
                    if (timeout) begin
                        rdata1_q <= '0;
                    end else if (!pwrite_q) begin
                        rdata1_q <= apb.prdata;
                    end
                end
            end
        end
    end

    assign req0_ready  = grant0;
    assign req1_ready  = grant1;
    assign req0_done   = done0_q;
    assign req1_done   = done1_q;
    assign req0_err    = err0_q;
    assign req1_err    = err1_q;
    assign req0_rdata  = rdata0_q;
    assign req1_rdata  = rdata1_q;

    assign apb.paddr   = paddr_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.psel    = psel_c;
    assign apb.penable = penable_c;
endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - randomized self-checking bench for apb_arbiter against a transaction-level model
module tb_apb_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } cmd_t;

    logic          pclk = 1'b0;
    logic          rst  = 1'b1;
    logic          req0_valid = 1'b0, req0_write = 1'b0;
    logic [AW-1:0] req0_addr  = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req0_ready, req0_done, req0_err;
    logic [DW-1:0] req0_rdata;
    logic          req1_valid = 1'b0, req1_write = 1'b0;
    logic [AW-1:0] req1_addr  = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req1_ready, req1_done, req1_err;
    logic [DW-1:0] req1_rdata;

    apb_arbiter_if #(.addrWidth(AW), .dataWidth(DW)) bus ();

    apb_arbiter #(.addrWidth(AW), .dataWidth(DW)) dut (
        .pclk       (pclk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_write (req0_write),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req0_done  (req0_done),
        .req0_rdata (req0_rdata),
        .req0_err   (req0_err),
        .req1_valid (req1_valid),
        .req1_write (req1_write),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .req1_done  (req1_done),
        .req1_rdata (req1_rdata),
        .req1_err   (req1_err),
        .apb        (bus)
    );

    always #5 pclk = ~pclk;

    int vectors = 0;
    int miscompares = 0;

    // transaction-level model state
    cmd_t          q0[$], q1[$];
    cmd_t          cur;
    bit            pres0, pres1;
    int            cyc = 0;
    int            exp_done = -1;
    int            gcyc = 0;
    int            owner_m = 0;
    int            last_served = 1;
    int            n_done = 0;
    int            grants[$];
    logic [DW-1:0] exp_rdata;
    logic [DW-1:0] last_rdata[2];
    logic [DW-1:0] ref_mem[bit [AW-1:0]];
    logic [DW-1:0] slv_mem[bit [AW-1:0]];
    int            slave_waits = 0;

    // Behavioural slave: inserts slave_waits wait states per access (negative = never ready).
    initial begin
        int wcnt;
        wcnt = 0;
        bus.pready = 1'b0;
        bus.prdata = '0;
        forever begin
            @(negedge pclk);
            if (bus.psel && bus.penable) begin
                if (slave_waits < 0 || wcnt < slave_waits) begin
                    bus.pready = 1'b0;
                    bus.prdata = $urandom;
                    wcnt++;
                end else begin
                    bus.pready = 1'b1;
                    wcnt = 0;
                    if (bus.pwrite) slv_mem[bus.paddr] = bus.pwdata;
                    else bus.prdata = slv_mem.exists(bus.paddr) ? slv_mem[bus.paddr] : '0;
                end
            end else begin
                bus.pready = 1'b0;
                bus.prdata = $urandom;
                wcnt = 0;
            end
        end
    end

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    task automatic do_reset();
        @(negedge pclk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge pclk);
        rst = 1'b0;
        last_served = 1;
        exp_done = -1;
        pres0 = 1'b0;
        pres1 = 1'b0;
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        q0.delete();
        q1.delete();
    endtask

    // Drive queued commands until all complete, checking every cycle against the model.
    task automatic run(input int waits, input int prob);
        int budget;
        int g;
        int ph;
        bit busy;
        bit exp_d;
        budget = 0;
        slave_waits = waits;
        while ((q0.size() != 0 || q1.size() != 0 || cyc < exp_done) && budget < 3000) begin
            @(negedge pclk);
            cyc++;
            budget++;
            if (!pres0 && q0.size() != 0 && int'($urandom_range(99)) < prob) pres0 = 1'b1;
            if (!pres1 && q1.size() != 0 && int'($urandom_range(99)) < prob) pres1 = 1'b1;
            req0_valid = pres0;
            req1_valid = pres1;
            if (q0.size() != 0) begin
                req0_write = q0[0].w; req0_addr = q0[0].a; req0_wdata = q0[0].d;
            end
            if (q1.size() != 0) begin
                req1_write = q1[0].w; req1_addr = q1[0].a; req1_wdata = q1[0].d;
            end
            #1;
            busy  = (cyc < exp_done);
            exp_d = (cyc == exp_done);

            vectors++;
            if (req0_done !== (exp_d && owner_m == 0) || req1_done !== (exp_d && owner_m == 1)) begin
                miscompares++;
                $display("FAIL done cyc=%0d: got %b%b expected %b%b", cyc, req1_done, req0_done,
                         exp_d && owner_m == 1, exp_d && owner_m == 0);
            end
            if (exp_d) begin
                n_done++;
                vectors++;
                if ((owner_m == 0 ? req0_rdata : req1_rdata) !== exp_rdata ||
                    (owner_m == 0 ? req0_err : req1_err) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rdata/err req%0d: got %h/%b expected %h/0", owner_m,
                             owner_m == 0 ? req0_rdata : req1_rdata,
                             owner_m == 0 ? req0_err : req1_err, exp_rdata);
                end
            end

            vectors++;
            if (busy) begin
                ph = cyc - gcyc;
                if (bus.psel !== 1'b1 || bus.penable !== (ph >= 2) || bus.paddr !== cur.a ||
                    bus.pwrite !== cur.w || (cur.w && bus.pwdata !== cur.d)) begin
                    miscompares++;
                    $display("FAIL apb phase %0d: got sel=%b en=%b a=%h w=%b d=%h expected sel=1 en=%b a=%h w=%b d=%h",
                             ph, bus.psel, bus.penable, bus.paddr, bus.pwrite, bus.pwdata,
                             ph >= 2, cur.a, cur.w, cur.d);
                end
            end else if (bus.psel !== 1'b0 || bus.penable !== 1'b0) begin
                miscompares++;
                $display("FAIL apb idle: got sel=%b en=%b expected 0 0", bus.psel, bus.penable);
            end

            if (busy) g = -1;
            else if (pres0 && pres1) g = (last_served == 0) ? 1 : 0;
            else if (pres0) g = 0;
            else if (pres1) g = 1;
            else g = -1;
            vectors++;
            if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
                miscompares++;
                $display("FAIL ready cyc=%0d: got %b%b expected %b%b", cyc, req1_ready, req0_ready,
                         g == 1, g == 0);
            end
            if (g >= 0) begin
                if (g == 0) begin cur = q0.pop_front(); pres0 = 1'b0; end
                else begin cur = q1.pop_front(); pres1 = 1'b0; end
                last_served = g;
                owner_m = g;
                gcyc = cyc;
                exp_done = cyc + 3 + waits;
                if (cur.w) begin
                    ref_mem[cur.a] = cur.d;
                    exp_rdata = last_rdata[g];
                end else begin
                    exp_rdata = ref_rd(cur.a);
                end
                last_rdata[g] = exp_rdata;
                grants.push_back(g);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        if (budget >= 3000) begin
            vectors++;
            miscompares++;
            $display("FAIL run timeout: got %0d cycles expected completion", budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        vectors++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || bus.pwrite !== 1'b0 ||
            bus.paddr !== '0 || bus.pwdata !== '0) begin
            miscompares++;
            $display("FAIL reset apb: got sel=%b en=%b w=%b a=%h d=%h expected all 0",
                     bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata);
        end
        vectors++;
        if (req0_done !== 1'b0 || req1_done !== 1'b0 || req0_err !== 1'b0 || req1_err !== 1'b0 ||
            req0_rdata !== '0 || req1_rdata !== '0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset req: got done=%b%b err=%b%b rd0=%h rd1=%h expected all 0",
                     req1_done, req0_done, req1_err, req0_err, req0_rdata, req1_rdata);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        q0.push_back('{w: 1'b1, a: 32'h10, d: 32'hA5A5_0001});
        run(0, 100);
    endtask

    task automatic test_read_back();
        q1.push_back('{w: 1'b0, a: 32'h10, d: 32'h0});
        run(0, 100);
        vectors++;
        if (req1_rdata !== 32'hA5A5_0001) begin
            miscompares++;
            $display("FAIL read_back: got %h expected a5a50001", req1_rdata);
        end
    endtask

    task automatic test_round_robin();
        int start;
        do_reset();
        grants.delete();
        start = n_done;
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{w: 1'b1, a: 32'h200 + i * 8, d: $urandom});
            q1.push_back('{w: 1'b0, a: 32'h200 + i * 8, d: '0});
        end
        run(0, 100);
        vectors++;
        if (n_done - start !== 8 || grants.size() !== 8) begin
            miscompares++;
            $display("FAIL rr count: got %0d dones %0d grants expected 8", n_done - start, grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
            vectors++;
            if (grants[i] !== i % 2) begin
                miscompares++;
                $display("FAIL rr order[%0d]: got %0d expected %0d", i, grants[i], i % 2);
            end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        q0.push_back('{w: 1'b1, a: 32'h44, d: 32'hCAFE_F00D});
        q1.push_back('{w: 1'b0, a: 32'h44, d: '0});
        run(3, 100);
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            do_reset();
            for (int i = 0; i < 6; i++) begin
                q0.push_back('{w: 1'($urandom), a: 32'h100 + 4 * $urandom_range(3), d: $urandom});
                q1.push_back('{w: 1'($urandom), a: 32'h100 + 4 * $urandom_range(3), d: $urandom});
            end
            run(int'($urandom_range(3)), 60);
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        slave_waits = -1;
        @(negedge pclk);
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h40; req0_wdata = 32'h1111_2222;
        #1;
        vectors++;
        if (req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL abort grant: got %b expected 1", req0_ready);
        end
        @(negedge pclk);
        req0_valid = 1'b0;
        @(negedge pclk);
        #1;
        vectors++;
        if (bus.psel !== 1'b1 || bus.penable !== 1'b1) begin
            miscompares++;
            $display("FAIL abort access: got sel=%b en=%b expected 1 1", bus.psel, bus.penable);
        end
        rst = 1'b1;
        @(negedge pclk);
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.psel !== 1'b0 || bus.penable !== 1'b0 || req0_done !== 1'b0 || req1_done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort state: got sel=%b en=%b done=%b%b expected 0 0 00",
                     bus.psel, bus.penable, req1_done, req0_done);
        end
        @(negedge pclk);
        req0_valid = 1'b1; req1_valid = 1'b1; req1_write = 1'b0;
        #1;
        vectors++;
        if (req0_done !== 1'b0 || req1_done !== 1'b0 || req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL abort regrant: got done=%b%b ready=%b%b expected 00 01",
                     req1_done, req0_done, req1_ready, req0_ready);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        int nchk;
        bit expd;
        do_reset();
        q1.push_back('{w: 1'b1, a: 32'h30, d: 32'h1234_5678});
        q1.push_back('{w: 1'b0, a: 32'h30, d: '0});
        run(0, 100);
        slave_waits = -1;
        @(negedge pclk);
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h30;
        #1;
        vectors++;
        if (req1_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout grant: got %b expected 1", req1_ready);
        end
`ifdef APB_ARB_TIMEOUT_EN
        nchk = 18;
`else
        nchk = 120;
`endif
        for (int k = 1; k <= nchk; k++) begin
            @(negedge pclk);
            req1_valid = 1'b0;
            #1;
`ifdef APB_ARB_TIMEOUT_EN
            expd = (k == 18);
`else
            expd = 1'b0;
`endif
            vectors++;
            if (bus.psel !== !expd || req1_done !== expd || req1_err !== expd || req0_done !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout k=%0d: got sel=%b done=%b err=%b expected sel=%b done=%b err=%b",
                         k, bus.psel, req1_done, req1_err, !expd, expd, expd);
            end
            if (expd) begin
                vectors++;
                if (req1_rdata !== '0) begin
                    miscompares++;
                    $display("FAIL timeout rdata: got %h expected 0", req1_rdata);
                end
            end
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_read_back();
        test_round_robin();
        test_wait_states();
        test_random();
        test_reset_abort();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
